// File: rtl/sel_cmp_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : sel_cmp_pipe_if
// Description : Bundles the transaction handshake, operand/flag fields,
//               statistics outputs and clear pulse of sel_cmp_pipe.
//               slave  - the pipeline side (consumes inputs, drives results)
//               master - the producer/consumer side (drives inputs)
// Ports       : in_valid/in_ready, a, b, flags, mode, exp  - input transaction
//               out_valid/out_ready, y                     - result delivery
//               ones_cnt, txn_cnt, err, clr                - statistics/control
// Revision    : 1.0 - initial release
// ============================================================================
interface sel_cmp_pipe_if #(
    parameter int W  = 4,
    parameter int NF = 4,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [NF-1:0] flags;
    logic [1:0]    mode;
    logic          exp;
    logic          clr;
    logic          out_valid;
    logic          out_ready;
    logic          y;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] txn_cnt;
    logic          err;

    modport slave (
        input  in_valid, a, b, flags, mode, exp, clr, out_ready,
        output in_ready, out_valid, y, ones_cnt, txn_cnt, err
    );

    modport master (
        output in_valid, a, b, flags, mode, exp, clr, out_ready,
        input  in_ready, out_valid, y, ones_cnt, txn_cnt, err
    );
endinterface
`default_nettype wire

// File: rtl/sel_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sel_cmp_pipe
// Description : Two-stage valid/ready pipeline computing a 1-bit selectable
//               compare/flag function. S1 holds the captured transaction,
//               S2 holds the result y and its expected value. Delivered
//               results update saturating statistics counters and a sticky
//               mismatch flag.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - sel_cmp_pipe_if.slave (handshakes, fields, statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module sel_cmp_pipe #(
    parameter int W  = 4,
    parameter int NF = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    sel_cmp_pipe_if.slave   bus
);

    localparam int SELW = (NF > 1) ? $clog2(NF) : 1;
    // Operand A is widened so the select mask also works when W < log2(NF).
    localparam int AW   = (W > SELW) ? W : SELW;
    localparam logic [AW-1:0] SEL_MASK = AW'(NF - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // ---------------- state ----------------
    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_a_q,     s1_a_d;
    logic [W-1:0]  s1_b_q,     s1_b_d;
    logic [NF-1:0] s1_flags_q, s1_flags_d;
    logic [1:0]    s1_mode_q,  s1_mode_d;
    logic          s1_exp_q,   s1_exp_d;
    logic          s2_valid_q, s2_valid_d;
    logic          y_q,        y_d;
    logic          s2_exp_q,   s2_exp_d;
    logic [CW-1:0] ones_cnt_q, ones_cnt_d;
    logic [CW-1:0] txn_cnt_q,  txn_cnt_d;
    logic          err_q,      err_d;

    // ---------------- control ----------------
    logic          w_s2_adv;
    logic          w_s1_adv;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_deliver;
    logic [AW-1:0] w_a_ext;
    logic          w_flag_sel;
    logic          w_y_func;

    assign w_s2_adv   = !s2_valid_q || bus.out_ready;
    assign w_s1_adv   = !s1_valid_q || w_s2_adv;
    // Combinational ready; held low during reset so nothing is taken then.
    assign w_in_ready = w_s1_adv && !rst;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_deliver  = s2_valid_q && bus.out_ready;

    // ---------------- result function on S1 contents ----------------
    always_comb begin
        w_a_ext    = AW'(s1_a_q);
        w_flag_sel = 1'b0;
        // Flag select uses only the low log2(NF) bits of A.
        for (int i = 0; i < NF; i++) begin
            if ((w_a_ext & SEL_MASK) == AW'(i)) begin
                w_flag_sel = s1_flags_q[i];
            end
        end
        case (s1_mode_q)
            2'b00:   w_y_func = (s1_a_q == s1_b_q);
            2'b01:   w_y_func = (s1_a_q > s1_b_q);
            2'b10:   w_y_func = ^s1_flags_q;
            default: w_y_func = w_flag_sel;
        endcase
    end

    // ---------------- next state ----------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_flags_d = s1_flags_q;
        s1_mode_d  = s1_mode_q;
        s1_exp_d   = s1_exp_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        s2_exp_d   = s2_exp_q;
        ones_cnt_d = ones_cnt_q;
        txn_cnt_d  = txn_cnt_q;
        err_d      = err_q;

        if (w_s1_adv) begin
            s1_valid_d = w_accept;
            if (w_accept) begin
                s1_a_d     = bus.a;
                s1_b_d     = bus.b;
                s1_flags_d = bus.flags;
                s1_mode_d  = bus.mode;
                s1_exp_d   = bus.exp;
            end
        end

        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            // y keeps its last value when S2 drains to empty.
            if (s1_valid_q) begin
                y_d      = w_y_func;
                s2_exp_d = s1_exp_q;
            end
        end

        // Clear has priority over a same-cycle delivery.
        if (bus.clr) begin
            ones_cnt_d = '0;
            txn_cnt_d  = '0;
            err_d      = 1'b0;
        end else if (w_deliver) begin
            if (txn_cnt_q != CNT_MAX) begin
                txn_cnt_d = txn_cnt_q + CW'(1);
            end
            if (y_q && (ones_cnt_q != CNT_MAX)) begin
                ones_cnt_d = ones_cnt_q + CW'(1);
            end
            if (y_q != s2_exp_q) begin
                err_d = 1'b1;
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_flags_q <= '0;
            s1_mode_q  <= 2'b00;
            s1_exp_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= 1'b0;
            s2_exp_q   <= 1'b0;
            ones_cnt_q <= '0;
            txn_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_flags_q <= s1_flags_d;
            s1_mode_q  <= s1_mode_d;
            s1_exp_q   <= s1_exp_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            s2_exp_q   <= s2_exp_d;
            ones_cnt_q <= ones_cnt_d;
            txn_cnt_q  <= txn_cnt_d;
            err_q      <= err_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.y         = y_q;
    assign bus.ones_cnt  = ones_cnt_q;
    assign bus.txn_cnt   = txn_cnt_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sel_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_cmp_pipe
// Description : Directed self-checking bench for sel_cmp_pipe. A CW=8
//               instance covers function, latency, backpressure, sticky
//               error, clear and reset; a CW=3 instance covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_cmp_pipe;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    sel_cmp_pipe_if #(.W(4), .NF(4), .CW(8)) u_if ();
    sel_cmp_pipe_if #(.W(4), .NF(4), .CW(3)) u_if3 ();

    sel_cmp_pipe #(.W(4), .NF(4), .CW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    sel_cmp_pipe #(.W(4), .NF(4), .CW(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (u_if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tbv,
                         input logic [3:0] tf, input logic [1:0] tm, input logic te);
        u_if.in_valid = v;
        u_if.a        = ta;
        u_if.b        = tbv;
        u_if.flags    = tf;
        u_if.mode     = tm;
        u_if.exp      = te;
    endtask

    // One isolated transaction on an empty pipeline with out_ready=1:
    // checks ready, the 2-cycle latency and y, then lets it deliver.
    task automatic txn_iso(input string tag, input logic [3:0] ta, input logic [3:0] tbv,
                           input logic [3:0] tf, input logic [1:0] tm, input logic te,
                           input logic ty);
        chk({tag, "_in_ready"}, 32'(u_if.in_ready), 1);
        drive(1'b1, ta, tbv, tf, tm, te);
        step();
        u_if.in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 32'(u_if.out_valid), 0);
        step();
        chk({tag, "_lat2_valid"}, 32'(u_if.out_valid), 1);
        chk({tag, "_y"}, 32'(u_if.y), 32'(ty));
        step();
    endtask

    logic [3:0] bp_a [5];
    logic [3:0] bp_b [5];
    logic [3:0] bp_f [5];
    logic [1:0] bp_m [5];
    logic       bp_y [5];
    int         idx;
    int         dcnt;
    logic       acc;

    initial begin
        bp_a = '{4'd5, 4'd1, 4'd0, 4'd0, 4'd1};
        bp_b = '{4'd2, 4'd1, 4'd7, 4'd0, 4'd0};
        bp_f = '{4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000};
        bp_m = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
        bp_y = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 1'b0);
        u_if.clr       = 1'b0;
        u_if.out_ready = 1'b1;
        u_if3.in_valid  = 1'b0;
        u_if3.a         = 4'd0;
        u_if3.b         = 4'd0;
        u_if3.flags     = 4'd0;
        u_if3.mode      = 2'b00;
        u_if3.exp       = 1'b1;
        u_if3.clr       = 1'b0;
        u_if3.out_ready = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_in_ready",  32'(u_if.in_ready), 0);
        chk("rst_out_valid", 32'(u_if.out_valid), 0);
        chk("rst_y",         32'(u_if.y), 0);
        chk("rst_txn_cnt",   32'(u_if.txn_cnt), 0);
        chk("rst_ones_cnt",  32'(u_if.ones_cnt), 0);
        chk("rst_err",       32'(u_if.err), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(u_if.in_ready), 1);

        // ---------------- mode sweep ----------------
        txn_iso("m00_eq",   4'd6, 4'd6, 4'b0000, 2'b00, 1'b1, 1'b1);
        txn_iso("m01_gt",   4'd3, 4'd9, 4'b0000, 2'b01, 1'b0, 1'b0);
        txn_iso("m10_xor",  4'd0, 4'd0, 4'b1011, 2'b10, 1'b1, 1'b1);
        txn_iso("m11_sel",  4'd2, 4'd0, 4'b0100, 2'b11, 1'b1, 1'b1);
        chk("sweep_txn_cnt",  32'(u_if.txn_cnt), 4);
        chk("sweep_ones_cnt", 32'(u_if.ones_cnt), 3);
        chk("sweep_err",      32'(u_if.err), 0);

        u_if.clr = 1'b1;
        step();
        u_if.clr = 1'b0;
        chk("clr1_txn_cnt", 32'(u_if.txn_cnt), 0);

        // ---------------- backpressure ----------------
        idx  = 0;
        dcnt = 0;
        for (int c = 0; c < 24 && dcnt < 5; c++) begin
            u_if.out_ready = (c >= 4);
            if (idx < 5) drive(1'b1, bp_a[idx], bp_b[idx], bp_f[idx], bp_m[idx], bp_y[idx]);
            else         u_if.in_valid = 1'b0;
            #1;
            if (c == 2 || c == 3) begin
                chk("bp_in_ready_low", 32'(u_if.in_ready), 0);
                chk("bp_accepted",     32'(idx), 2);
                chk("bp_hold_valid",   32'(u_if.out_valid), 1);
                chk("bp_hold_y",       32'(u_if.y), 1);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                chk("bp_order_y", 32'(u_if.y), 32'(bp_y[dcnt]));
                dcnt++;
            end
            acc = u_if.in_valid && u_if.in_ready;
            step();
            if (acc) idx++;
        end
        u_if.in_valid = 1'b0;
        u_if.out_ready = 1'b1;
        chk("bp_delivered", 32'(dcnt), 5);
        chk("bp_txn_cnt",   32'(u_if.txn_cnt), 5);
        chk("bp_ones_cnt",  32'(u_if.ones_cnt), 3);
        chk("bp_drained",   32'(u_if.out_valid), 0);

        // ---------------- sticky error ----------------
        txn_iso("err_bad", 4'd1, 4'd1, 4'b0000, 2'b00, 1'b0, 1'b1);
        chk("err_set", 32'(u_if.err), 1);
        txn_iso("err_ok1", 4'd7, 4'd2, 4'b0000, 2'b01, 1'b1, 1'b1);
        chk("err_hold1", 32'(u_if.err), 1);
        txn_iso("err_ok2", 4'd2, 4'd7, 4'b0000, 2'b01, 1'b0, 1'b0);
        chk("err_hold2", 32'(u_if.err), 1);
        txn_iso("err_ok3", 4'd0, 4'd0, 4'b0001, 2'b10, 1'b1, 1'b1);
        chk("err_hold3", 32'(u_if.err), 1);
        u_if.clr = 1'b1;
        step();
        u_if.clr = 1'b0;
        chk("err_clr",     32'(u_if.err), 0);
        chk("err_clr_txn", 32'(u_if.txn_cnt), 0);

        // ---------------- clr / delivery collision ----------------
        drive(1'b1, 4'd2, 4'd1, 4'b0000, 2'b01, 1'b0);
        step();
        u_if.in_valid = 1'b0;
        step();
        chk("coll_valid", 32'(u_if.out_valid), 1);
        u_if.clr = 1'b1;
        step();
        u_if.clr = 1'b0;
        chk("coll_txn_cnt",  32'(u_if.txn_cnt), 0);
        chk("coll_ones_cnt", 32'(u_if.ones_cnt), 0);
        chk("coll_err",      32'(u_if.err), 0);
        chk("coll_drained",  32'(u_if.out_valid), 0);
        txn_iso("coll_next", 4'd0, 4'd0, 4'b0000, 2'b00, 1'b1, 1'b1);
        chk("coll_next_txn", 32'(u_if.txn_cnt), 1);

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 4'd5, 4'd3, 4'b0000, 2'b01, 1'b1);
        step();
        drive(1'b1, 4'd4, 4'd4, 4'b0000, 2'b00, 1'b1);
        step();
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        chk("mid_inflight_valid", 32'(u_if.out_valid), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid",    32'(u_if.out_valid), 0);
        chk("mid_rst_in_ready", 32'(u_if.in_ready), 0);
        chk("mid_rst_txn",      32'(u_if.txn_cnt), 0);
        rst = 1'b0;
        u_if.out_ready = 1'b1;
        #1;
        chk("mid_post_in_ready", 32'(u_if.in_ready), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_no_stale", 32'(u_if.out_valid), 0);
        end
        txn_iso("mid_new", 4'd2, 4'd3, 4'b0000, 2'b01, 1'b0, 1'b0);
        chk("mid_new_txn",  32'(u_if.txn_cnt), 1);
        chk("mid_new_ones", 32'(u_if.ones_cnt), 0);
        chk("mid_new_err",  32'(u_if.err), 0);

        // ---------------- saturation (CW=3) ----------------
        u_if3.in_valid = 1'b1;
        repeat (10) step();
        u_if3.in_valid = 1'b0;
        repeat (3) step();
        chk("sat_txn_cnt",  32'(u_if3.txn_cnt), 7);
        chk("sat_ones_cnt", 32'(u_if3.ones_cnt), 7);
        chk("sat_err",      32'(u_if3.err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sel_cmp_pipe.md
SEL_CMP_PIPE -- requirements
Module: sel_cmp_pipe

Interface
REQ-001 Parameter W, default 4, operand width in bits (legal range 2..16).
REQ-002 Parameter NF, default 4, flag-vector width (power of 2, legal range 2..16).
REQ-003 Parameter CW, default 8, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input transaction present.
REQ-007 in_ready  out  1  block accepts the input this cycle.
REQ-008 a  in  W  operand A, unsigned.
REQ-009 b  in  W  operand B, unsigned.
REQ-010 flags  in  NF  single-bit condition inputs.
REQ-011 mode  in  2  function select, sampled with the transaction.
REQ-012 exp  in  1  expected result, carried with the transaction for self-check.
REQ-013 clr  in  1  synchronous clear pulse for the statistics and the sticky error.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 y  out  1  registered result.
REQ-017 ones_cnt  out  CW  delivered results with y=1.
REQ-018 txn_cnt  out  CW  delivered results.
REQ-019 err  out  1  sticky flag: a delivered y differed from its exp.

Function
REQ-020 An input is accepted on a cycle where in_valid=1 and in_ready=1; a, b, flags, mode, and exp are captured together.
REQ-021 A result is delivered on a cycle where out_valid=1 and out_ready=1.
REQ-022 The block is a two-stage pipeline: S1 holds the captured fields; S2 holds y and exp.
REQ-023 mode 00: y = (a == b).
REQ-024 mode 01: y = (a > b), unsigned.
REQ-025 mode 10: y = XOR-reduction of flags.
REQ-026 mode 11: y = flags[a[log2(NF)-1:0]]; the upper bits of a are ignored.
REQ-027 S2 advances when S2 is empty or out_ready=1; S1 advances when S1 is empty or S2 advances.
REQ-028 in_ready = S1 advance condition, combinational; it is forced to 0 while rst=1.
REQ-029 Latency: an input accepted in cycle n gives out_valid=1 in cycle n+2 when there is no backpressure.
REQ-030 Throughput is one transaction per cycle while out_ready=1.
REQ-031 Under backpressure, y, out_valid, and the buffered transactions hold unchanged and none are dropped or duplicated; at most 2 transactions are in flight.
REQ-032 On delivery: txn_cnt += 1; ones_cnt += 1 if y=1; both saturate at 2^CW-1 with no wrap.
REQ-033 On delivery with y != exp, err is set to 1 and holds until clr or rst.
REQ-034 clr=1 zeroes ones_cnt, txn_cnt, and err in the next cycle.
REQ-035 If clr and a delivery occur in the same cycle, clr wins: counters are 0, err is 0, and that delivery is not counted.
REQ-036 clr does not affect the pipeline contents, out_valid, or in_ready.
REQ-037 Simultaneous accept and deliver in the same cycle is legal; occupancy is unchanged.

Reset
REQ-038 While rst=1: S1 and S2 are empty, out_valid=0, y=0, ones_cnt=0, txn_cnt=0, err=0, in_ready=0.
REQ-039 An assertion of rst mid-stream discards all in-flight transactions, which are never delivered.
REQ-040 in_ready=1 in the first cycle after rst deasserts, with in_valid=0 required at that cycle's edge.

Verification
REQ-041 The bench SHALL cover the mode sweep, W=4, NF=4, out_ready=1:
  - (a=6,b=6,m=00) -> y=1
  - (a=3,b=9,m=01) -> y=0
  - (flags=1011,m=10) -> y=1
  - (a=2,flags=0100,m=11) -> y=1
  - each result appears exactly 2 cycles after acceptance.
REQ-042 The bench SHALL cover backpressure: stream 5 transactions with out_ready=0 for 4 cycles.
  - in_ready=0 after 2 are accepted.
  - All 5 are delivered in order with correct y after out_ready returns to 1.
  - txn_cnt=5.
REQ-043 The bench SHALL cover self-check: one transaction with exp opposite to y.
  - err=1 after delivery; it stays 1 through 3 further correct transactions.
  - clr pulse -> err=0 and txn_cnt=0.
REQ-044 The bench SHALL cover saturation with CW=3: deliver 10 transactions with y=1 -> txn_cnt=7 and ones_cnt=7.
REQ-045 The bench SHALL cover clr/delivery collision: clr in a delivery cycle -> counters 0 the next cycle, and the following delivery -> txn_cnt=1.
REQ-046 The bench SHALL cover reset mid-operation: rst for 1 cycle with 2 transactions in flight -> out_valid=0 and no delivery of those transactions; a new transaction after reset -> correct y, and txn_cnt counts only that transaction.
